// File: rtl/switch_mcu_ahb_sram_slave.sv
// AHB-lite SRAM responder for the switch MCU core bus.
// Word RAM with wait states, byte/halfword strobes and two-cycle ERROR.
module switch_mcu_ahb_sram_slave #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic [31:0] in_haddr,
  input  logic        in_hwrite,
  input  logic [3:0]  in_hsize,
  input  logic [2:0]  in_hburst,
  input  logic [3:0]  in_hport,
  input  logic [1:0]  in_htrans,
  input  logic        in_hmastlock,
  input  logic [31:0] in_hwdata,
  output logic        out_hready,
  output logic        out_hresp,
  output logic [31:0] out_hrdata
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [3:0]    cnt;
  logic          pend_wr;
  logic [AW-1:0] dp_idx;
  logic [3:0]    dp_strb;

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic [3:0]    strb;
  logic          in_range;
  logic          size_ok;
  logic          misaligned;
  logic          legal;
  logic          accept;
  logic          wr_fire;
  logic [31:0]   rd_word;
  logic          unused_inputs;

  assign unused_inputs = ^{in_hburst, in_hport, in_hmastlock,
                           in_htrans[0], off[1:0]};

  assign off        = in_haddr - BASE_ADDR;
  assign idx        = off[AW+1:2];
  assign in_range   = (off[31:AW+2] == '0);
  assign size_ok    = (in_hsize[3:2] == 2'b00) &&
                      (in_hsize[1:0] != 2'b11);
  assign misaligned = ((in_hsize == 4'd1) && in_haddr[0]) ||
                      ((in_hsize == 4'd2) && (in_haddr[1:0] != 2'b00));
  assign legal      = in_range && size_ok && !misaligned;
  assign accept     = out_hready && in_htrans[1];
  assign wr_fire    = out_hready && pend_wr;

  always_comb begin
    strb = 4'b1111;
    unique case (1'b1)
      (in_hsize[1:0] == 2'd0): strb = 4'b0001 << in_haddr[1:0];
      (in_hsize[1:0] == 2'd1): strb = in_haddr[1] ? 4'b1100 : 4'b0011;
      default:                 strb = 4'b1111;
    endcase
  end

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  s
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = s[i] ? nw[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  // Bypass a write completing this cycle into a read of the same word.
  assign rd_word = (wr_fire && (dp_idx == idx)) ?
                   merge(mem[idx], in_hwdata, dp_strb) : mem[idx];

  always_ff @(posedge in_clk) begin
    if (!in_rst && wr_fire) begin
      for (int i = 0; i < 4; i++)
        if (dp_strb[i])
          mem[dp_idx][8*i +: 8] <= in_hwdata[8*i +: 8];
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state      <= S_IDLE;
      out_hready <= 1'b1;
      out_hresp  <= 1'b0;
      out_hrdata <= '0;
      cnt        <= '0;
      pend_wr    <= 1'b0;
      dp_idx     <= '0;
      dp_strb    <= '0;
    end else begin
      unique case (state)
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= S_IDLE;
            out_hready <= 1'b1;
            if (!pend_wr)
              out_hrdata <= mem[dp_idx];
          end
        end
        S_ERR1: begin
          state      <= S_ERR2;
          out_hready <= 1'b1;
          out_hresp  <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          out_hready <= 1'b1;
          out_hresp  <= 1'b0;
          pend_wr    <= 1'b0;
          if (accept) begin
            dp_idx  <= idx;
            dp_strb <= strb;
            if (!legal) begin
              state      <= S_ERR1;
              out_hready <= 1'b0;
              out_hresp  <= 1'b1;
              if (!in_hwrite)
                out_hrdata <= '0;
            end else begin
              pend_wr <= in_hwrite;
              if (WAIT_CYCLES > 0) begin
                state      <= S_WAIT;
                cnt        <= 4'(WAIT_CYCLES);
                out_hready <= 1'b0;
              end else if (!in_hwrite) begin
                out_hrdata <= rd_word;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/switch_mcu_ahb_sram_slave.md
Name: switch_mcu_ahb_sram_slave

Overview:
- AHB-lite style responder that terminates the MCU core bus (haddr/htrans/hsize/hwrite to hready/hresp/hrdata).
- Adds the write-data path (in_hwdata) that the dummy SRAM model lacks.
- Provides a word-organised on-chip RAM with programmable wait states, byte and halfword write strobing, and a two-cycle ERROR response.
- Replaces the dummy SRAM as the core's data/instruction memory in the switch MCU subsystem.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*DEPTH.
- WAIT_CYCLES, 0, wait states inserted in every OKAY data phase; range 0..15.

Ports:
- in_clk  input  1  clock; all logic on rising edge.
- in_rst  input  1  synchronous reset, active-high.
- in_haddr  input  32  byte address, address phase.
- in_hwrite  input  1  1=write, 0=read.
- in_hsize  input  4  0=byte, 1=halfword, 2=word; any other value is illegal.
- in_hburst  input  3  burst type; ignored, because the master supplies every beat address.
- in_hport  input  4  protection; ignored.
- in_htrans  input  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
- in_hmastlock  input  1  ignored; there is only a single master.
- in_hwdata  input  32  write data, valid in the data phase.
- out_hready  output  1  data-phase completion and address acceptance.
- out_hresp  output  1  0=OKAY, 1=ERROR.
- out_hrdata  output  32  read data, valid when out_hready=1 in a read data phase.

Behaviour:
- Reset (in_rst=1 at a clock edge):
  - state goes to IDLE; out_hready=1, out_hresp=0, out_hrdata=0.
  - any pending transfer is dropped and no RAM write occurs.
  - RAM contents are not cleared.
- Address phase acceptance:
  - a transfer is accepted when out_hready=1 and in_htrans is NONSEQ or SEQ.
  - on acceptance, latch addr, write, size and a legality flag.
  - IDLE and BUSY transfers get a zero-wait OKAY response (out_hready=1, out_hresp=0) and have no side effects.
- Legality: a transfer is illegal if any of the following holds:
  - the address is outside [BASE_ADDR, BASE_ADDR+4*DEPTH).
  - hsize is greater than 2.
  - the address is misaligned: halfword with haddr[0]=1, or word with haddr[1:0]!=0.
- Word index is (haddr-BASE_ADDR)>>2, truncated to log2(DEPTH) bits.
- State machine, states IDLE, WAIT, ERR1, ERR2:
  - IDLE, legal accept with WAIT_CYCLES=0: the next cycle is the completing data phase. Stay in IDLE/issue state; out_hready=1.
  - IDLE, legal accept with WAIT_CYCLES>0: go to WAIT, load the counter with WAIT_CYCLES, drive out_hready=0.
    - The counter decrements each cycle.
    - At 0, out_hready=1 for one cycle (completion), then the FSM returns to accept behaviour.
  - Illegal accept goes to ERR1: out_hready=0, out_hresp=1.
    - Then ERR2: out_hready=1, out_hresp=1.
    - Then return to IDLE. WAIT_CYCLES does not apply to errors.
  - An address phase presented during WAIT or ERR1 (out_hready=0) is not accepted. The master must hold it.
  - The master may change htrans to IDLE during ERR2; this cancels the next beat. Both behaviours are legal and must be handled.
- Writes:
  - the RAM is updated on the edge that ends the completing data phase (out_hready=1), using in_hwdata at that edge.
  - Byte lane enables come from the latched size and addr[1:0]: byte writes one lane, halfword writes lanes {addr[1],0}+1..0, word writes all four lanes.
  - Lanes not enabled keep their value.
  - Errored writes never modify the RAM.
- Reads:
  - out_hrdata carries the full 32-bit word; the master selects lanes.
  - out_hrdata is valid only in the completing cycle. It holds its last value otherwise, and is 0 after reset.
  - An errored read drives out_hrdata=0.
- Read-after-write hazard:
  - with WAIT_CYCLES=0, a read whose address phase overlaps the data phase of a write to the same word must return the merged, newly written data.
  - This is done with a lane-wise bypass from the write register.
- Throughput:
  - back-to-back pipelined transfers complete one per (WAIT_CYCLES+1) cycles.
  - A SEQ beat is handled identically to NONSEQ.
- hresp is 1 only in ERR1/ERR2.

Test Plan:
- Reset: hold in_rst=1 for 2 clocks, then release -> out_hready=1, out_hresp=0, out_hrdata=0; an IDLE htrans for 5 cycles gives no RAM change.
- Word write then read, WAIT_CYCLES=0:
  - NONSEQ write 0x10 with data 0xDEADBEEF, then NONSEQ read 0x10 in the next address phase.
  - Expect read data 0xDEADBEEF one cycle after the read address phase, via the bypass path, with out_hready never low.
- Byte and halfword strobes:
  - word 0x20 holds 0x11223344.
  - Byte write 0x23 with hwdata 0xAA000000, then halfword write 0x20 with hwdata 0x0000BBCC.
  - Read 0x20 -> 0xAA22BBCC.
- Wait states, WAIT_CYCLES=3: a 4-beat SEQ read burst 0x40..0x4C -> each beat has out_hready low for exactly 3 cycles then high for 1; total 16 cycles; data matches preload.
- Error:
  - read to BASE_ADDR+4*DEPTH -> ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1), then OKAY idle.
  - Misaligned word write 0x22 gives the same two-cycle ERROR, and word 0x20 is unchanged.
- Reset mid-operation: assert in_rst during WAIT of a write to 0x30 -> no RAM update at 0x30; outputs return to reset values on the next edge.
